// File: rtl/sram_like_arbiter_pkg.sv
// Shared definitions for the sram-like bus arbiter.
//   - Owner encoding, one bit, stored in the response order FIFO.
//   - Access size codes carried on the size fields.
//   - req_fields_t bundles one requester's address-phase fields for the mux.
package sram_like_arbiter_pkg;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } req_fields_t;

endpackage

// File: rtl/sram_like_arbiter_order.sv
// sram_order_fifo: remembers which requester owns each issued-but-unanswered
// downstream request, oldest first.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   i_push     write i_din at the tail (caller guarantees not full)
//   i_din      owner bit to store
//   i_pop      drop the head entry (caller guarantees not empty)
//   o_head     owner bit of the oldest entry
//   o_count    number of stored entries, 0..DEPTH
//   o_full     o_count == DEPTH
//   o_empty    o_count == 0
module sram_order_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_din,
    input  logic                     i_pop,
    output logic                     o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem    <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_din;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == DEPTH_CNT);
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one downstream sram-like bus between instruction
// fetch (I) and the MEM stage (D), one address phase at a time, and returns
// each in-order downstream response to the requester that issued it.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   inst_* / data_*               requester buses: req + fields in,
//                                 addr_ok / data_ok / rdata out
//   req/wr/size/addr/wstrb/wdata  downstream address phase out
//   addr_ok, data_ok, rdata       downstream accept / response in
//   proto_err                     sticky: data_ok seen with nothing outstanding
//
// Handshake: a requester raises *_req with stable fields and holds them until
// *_addr_ok is seen high in the same cycle; that cycle is the transfer. The
// downstream transfer is req & addr_ok. Responses (*_data_ok) are single-cycle
// pulses with rdata valid only in that cycle; stores are acknowledged the same way.
module sram_like_arbiter
    import sram_like_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [3:0]  inst_wstrb,
    input  logic [31:0] inst_wdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        req,
    output logic        wr,
    output logic [1:0]  size,
    output logic [31:0] addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    input  logic        addr_ok,
    input  logic        data_ok,
    input  logic [31:0] rdata,
    output logic        proto_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] MAX_CNT    = CW'(MAX_OUTSTANDING);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

    logic          r_lock;
    logic          r_lock_owner;
    logic [SW-1:0] r_streak;
    logic          r_proto_err;

    logic          w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;

    logic          w_can_issue;
    logic          w_starve;
    logic          w_owner_req;
    logic          w_grant_valid;
    logic          w_grant_owner;
    logic          w_hs;
    logic          w_push;
    logic          w_pop;
    logic          w_err;

    req_fields_t   w_i_f;
    req_fields_t   w_d_f;
    req_fields_t   w_sel_f;

    assign w_i_f = '{wr: inst_wr, size: inst_size, addr: inst_addr,
                     wstrb: inst_wstrb, wdata: inst_wdata};
    assign w_d_f = '{wr: data_wr, size: data_size, addr: data_addr,
                     wstrb: data_wstrb, wdata: data_wdata};

    // Issue gate uses the registered count; a response in this cycle does
    // not free a slot until the next one.
    assign w_can_issue = (w_count < MAX_CNT);
    assign w_starve    = (r_streak == STREAK_MAX) && inst_req;
    assign w_owner_req = (r_lock_owner == OWN_I) ? inst_req : data_req;

    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_owner = OWN_D;
        if (!rst && w_can_issue) begin
            if (r_lock) begin
                // Locked: only the owner may continue; a dropped req (flush)
                // leaves the bus idle this cycle and unlocks next cycle.
                w_grant_valid = w_owner_req;
                w_grant_owner = r_lock_owner;
            end else if (w_starve) begin
                w_grant_valid = 1'b1;
                w_grant_owner = OWN_I;
            end else if (data_req) begin
                w_grant_valid = 1'b1;
                w_grant_owner = OWN_D;
            end else if (inst_req) begin
                w_grant_valid = 1'b1;
                w_grant_owner = OWN_I;
            end
        end
    end

    assign w_sel_f = !w_grant_valid ? '0 :
                     (w_grant_owner == OWN_D) ? w_d_f : w_i_f;

    assign req   = w_grant_valid;
    assign wr    = w_sel_f.wr;
    assign size  = w_sel_f.size;
    assign addr  = w_sel_f.addr;
    assign wstrb = w_sel_f.wstrb;
    assign wdata = w_sel_f.wdata;

    assign w_hs         = w_grant_valid & addr_ok;
    assign inst_addr_ok = w_hs & (w_grant_owner == OWN_I);
    assign data_addr_ok = w_hs & (w_grant_owner == OWN_D);

    // w_hs already implies a free slot; the full guard keeps the FIFO safe
    // even if the gate is ever changed.
    assign w_push = w_hs & ~w_full;
    assign w_pop  = data_ok & ~w_empty & ~rst;
    assign w_err  = data_ok &  w_empty & ~rst;

    assign inst_data_ok = w_pop & (w_head == OWN_I);
    assign data_data_ok = w_pop & (w_head == OWN_D);
    assign inst_rdata   = inst_data_ok ? rdata : 32'h0;
    assign data_rdata   = data_data_ok ? rdata : 32'h0;
    assign proto_err    = r_proto_err & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock       <= 1'b0;
            r_lock_owner <= OWN_I;
            r_streak     <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            if (w_grant_valid && !addr_ok) begin
                r_lock       <= 1'b1;
                r_lock_owner <= w_grant_owner;
            end else begin
                r_lock       <= 1'b0;
            end

            // Streak counts D transfers that overtook a waiting I request.
            if (!inst_req) begin
                r_streak <= '0;
            end else if (w_hs) begin
                if (w_grant_owner == OWN_I) begin
                    r_streak <= '0;
                end else if (r_streak != STREAK_MAX) begin
                    r_streak <= r_streak + 1'b1;
                end
            end

            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    sram_order_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_order (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_grant_owner),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Bench for sram_like_arbiter: random requesters and a downstream memory model
// driven once per cycle; a monitor compares every cycle against a queue-based
// reference of the arbitration and response-routing rules.
module tb_sram_like_arbiter;
    import sram_like_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0, inst_wr = 1'b0;
    logic [1:0]  inst_size = 2'b0;
    logic [31:0] inst_addr = 32'h0, inst_wdata = 32'h0;
    logic [3:0]  inst_wstrb = 4'h0;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req = 1'b0, data_wr = 1'b0;
    logic [1:0]  data_size = 2'b0;
    logic [31:0] data_addr = 32'h0, data_wdata = 32'h0;
    logic [3:0]  data_wstrb = 4'h0;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        req, wr;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok = 1'b0, data_ok = 1'b0;
    logic [31:0] rdata = 32'h0;
    logic        proto_err;

    sram_like_arbiter #(.MAX_OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wstrb(inst_wstrb), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wstrb(data_wstrb), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .req(req), .wr(wr), .size(size), .addr(addr), .wstrb(wstrb), .wdata(wdata),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_i[$];
    logic [31:0] exp_d[$];
    logic [31:0] ds_q[$];

    int p_i = 0, p_d = 0, p_aok = 100, p_dok = 100, p_flush = 0;
    bit force_dok = 1'b0;
    bit acc_i_q = 1'b0, acc_d_q = 1'b0;
    int n_i_acc = 0, n_d_acc = 0;

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, got, want, $time);
        end
    endtask

    // Downstream memory answers every access with a value derived from its address.
    function automatic logic [31:0] resp_of(input logic [31:0] a);
        return a ^ 32'h5a3c_96e1;
    endfunction

    task automatic do_reset(input int n);
        @(posedge clk); #1;
        rst = 1'b1;
        inst_req = 1'b0; data_req = 1'b0; addr_ok = 1'b0; data_ok = 1'b0;
        exp_i.delete(); exp_d.delete(); ds_q.delete();
        acc_i_q = 1'b0; acc_d_q = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One clock of stimulus: drive after the edge, record handshakes at negedge.
    task automatic step();
        @(posedge clk); #1;
        if (inst_req && !acc_i_q) begin
            if ($urandom_range(99) < p_flush) inst_req = 1'b0;
        end else begin
            inst_req   = ($urandom_range(99) < p_i);
            inst_wr    = 1'b0;
            inst_size  = SZ_W;
            inst_addr  = $urandom() & 32'hffff_fffc;
            inst_wstrb = 4'h0;
            inst_wdata = 32'h0;
        end
        if (data_req && !acc_d_q) begin
            if ($urandom_range(99) < p_flush) data_req = 1'b0;
        end else begin
            data_req   = ($urandom_range(99) < p_d);
            data_wr    = $urandom_range(1);
            data_size  = 2'($urandom_range(2));
            data_addr  = $urandom();
            data_wstrb = data_wr ? 4'($urandom_range(15)) : 4'h0;
            data_wdata = $urandom();
        end
        addr_ok = ($urandom_range(99) < p_aok);
        data_ok = force_dok || (ds_q.size() > 0 && $urandom_range(99) < p_dok);
        rdata   = (ds_q.size() > 0) ? ds_q[0] : $urandom();

        @(negedge clk);
        acc_i_q = inst_addr_ok;
        acc_d_q = data_addr_ok;
        if (acc_i_q) begin exp_i.push_back(resp_of(inst_addr)); n_i_acc++; end
        if (acc_d_q) begin exp_d.push_back(resp_of(data_addr)); n_d_acc++; end
        if (data_ok && ds_q.size() > 0) void'(ds_q.pop_front());
        if (req && addr_ok) ds_q.push_back(resp_of(addr));
    endtask

    // Reference: D beats I unless 8 D transfers overtook a waiting I; an
    // unaccepted requester keeps the bus; at most 4 outstanding; responses
    // go back in transfer order.
    initial begin : monitor
        int m_out;
        int m_run;
        int m_hold;
        int e_own;
        bit m_perr;
        bit resp, e_i, e_d;
        bit own_q[$];
        m_out = 0; m_run = 0; m_hold = -1; m_perr = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_outs", {req, inst_addr_ok, data_addr_ok, inst_data_ok,
                                   data_data_ok, proto_err, (|addr)}, 72'h0);
                m_out = 0; m_run = 0; m_hold = -1; m_perr = 1'b0;
                own_q.delete();
                continue;
            end
            e_own = -1;
            if (m_out < 4) begin
                if (m_hold == 0)              e_own = inst_req ? 0 : -1;
                else if (m_hold == 1)         e_own = data_req ? 1 : -1;
                else if (inst_req && m_run >= 8) e_own = 0;
                else if (data_req)            e_own = 1;
                else if (inst_req)            e_own = 0;
            end
            check("req", req, e_own >= 0);
            check("inst_addr_ok", inst_addr_ok, (e_own == 0) && addr_ok);
            check("data_addr_ok", data_addr_ok, (e_own == 1) && addr_ok);
            if (e_own == 0)
                check("fields_i", {wr, size, addr, wstrb, wdata},
                      {inst_wr, inst_size, inst_addr, inst_wstrb, inst_wdata});
            if (e_own == 1)
                check("fields_d", {wr, size, addr, wstrb, wdata},
                      {data_wr, data_size, data_addr, data_wstrb, data_wdata});

            resp = data_ok && (m_out > 0);
            e_i  = resp && (own_q[0] == 1'b0);
            e_d  = resp && (own_q[0] == 1'b1);
            check("inst_data_ok", inst_data_ok, e_i);
            check("data_data_ok", data_data_ok, e_d);
            if (inst_data_ok) begin
                if (exp_i.size() == 0) check("inst_rdata_unexpected", 1, 0);
                else check("inst_rdata", inst_rdata, exp_i.pop_front());
            end else begin
                check("inst_rdata_idle", inst_rdata, 0);
            end
            if (data_data_ok) begin
                if (exp_d.size() == 0) check("data_rdata_unexpected", 1, 0);
                else check("data_rdata", data_rdata, exp_d.pop_front());
            end else begin
                check("data_rdata_idle", data_rdata, 0);
            end
            check("proto_err", proto_err, m_perr);

            if (data_ok && m_out == 0) m_perr = 1'b1;
            if (e_own >= 0 && addr_ok) begin
                m_out++;
                own_q.push_back(e_own == 1);
                if (e_own == 1 && inst_req) m_run = (m_run < 8) ? m_run + 1 : 8;
                else m_run = 0;
            end else if (!inst_req) begin
                m_run = 0;
            end
            if (resp) begin
                m_out--;
                void'(own_q.pop_front());
            end
            m_hold = (e_own >= 0 && !addr_ok) ? e_own : -1;
        end
    end

    initial begin : stimulus
        do_reset(3);

        // Both requesters in the same cycle: D first, then I.
        p_i = 100; p_d = 100; p_aok = 100; p_dok = 100; p_flush = 0;
        repeat (1) step();
        p_i = 0; p_d = 0;
        repeat (6) step();

        // Fill four I requests with no responses, then release one at a time.
        p_i = 100; p_dok = 0;
        repeat (8) step();
        p_dok = 100;
        repeat (8) step();
        p_i = 0;
        repeat (8) step();

        // I locked while addr_ok stays low; D arrives meanwhile.
        p_i = 100; p_aok = 0;
        repeat (1) step();
        p_i = 0; p_d = 100;
        repeat (3) step();
        p_aok = 100; p_d = 0;
        repeat (8) step();

        // Starvation: 27 back-to-back transfers give D,x8 then I, three times.
        do_reset(2);
        p_i = 100; p_d = 100; p_aok = 100; p_dok = 100;
        n_i_acc = 0; n_d_acc = 0;
        repeat (27) step();
        check("starve_i_grants", n_i_acc, 3);
        check("starve_d_grants", n_d_acc, 24);
        p_i = 0; p_d = 0;
        repeat (8) step();

        // Spurious response with nothing outstanding: sticky error until reset.
        force_dok = 1'b1;
        step();
        force_dok = 1'b0;
        repeat (3) step();
        check("proto_sticky", proto_err, 1);
        do_reset(2);
        step();
        check("proto_cleared", proto_err, 0);

        // Store and load in flight, then reset; next request completes normally.
        p_i = 100; p_d = 100; p_dok = 0;
        repeat (3) step();
        do_reset(1);
        p_i = 0; p_d = 0; p_dok = 100;
        repeat (4) step();
        p_d = 100;
        step();
        p_d = 0;
        repeat (6) step();

        // Randomised traffic with occasional flushes.
        for (int blk = 0; blk < 30; blk++) begin
            p_i     = $urandom_range(100);
            p_d     = $urandom_range(100);
            p_aok   = $urandom_range(100, 20);
            p_dok   = $urandom_range(100, 20);
            p_flush = $urandom_range(10);
            repeat (100) step();
        end

        // Drain everything outstanding.
        p_i = 0; p_d = 0; p_aok = 100; p_dok = 100; p_flush = 0;
        for (int k = 0; k < 60 && (ds_q.size() > 0 || inst_req || data_req); k++) step();
        repeat (2) step();
        check("drain_ds", ds_q.size(), 0);
        check("drain_i", exp_i.size(), 0);
        check("drain_d", exp_d.size(), 0);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
